// File: rtl/iirinv.sv
// -----------------------------------------------------------------------------
// iirinv -- inverse of a first-order recursive averager.
//
// The averager y[n] = y[n-1] + alpha*(x[n] - y[n-1]), alpha = 2^-LGALPHA, is
// undone by  x[n] = y[n-1] + ((y[n] - y[n-1]) << LGALPHA).
// The result is range-handled to the signed IW range and truncated to OW bits.
//
// Build option:
//   IIRINV_SATURATE_EN  defined   -> out-of-range results are clamped
//                       undefined -> out-of-range results wrap (two's complement)
//   In both builds o_sat flags (stickily) any out-of-range result.
//
// Ports:
//   i_clk      clock, all logic rising-edge
//   i_reset_n  synchronous active-low reset, priority over everything
//   i_ce       sample strobe, i_data valid when high
//   i_data     signed averaged sample y[n] (IW bits)
//   o_valid    one-cycle strobe marking a new o_data
//   o_data     signed recovered sample x[n] (OW bits), held while o_valid low
//   o_sat      sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module iirinv #(
    parameter int IW      = 16,
    parameter int OW      = 15,
    parameter int LGALPHA = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    output logic          o_valid,
    output logic [OW-1:0] o_data,
    output logic          o_sat
);

    // Full-precision width of e: IW+1 bit difference shifted by LGALPHA plus
    // one bit of headroom for the addition of yprev.
    localparam int EW = IW + LGALPHA + 2;

    logic [IW-1:0]    yprev_q,    yprev_d;
    logic             primed_q,   primed_d;
    logic             s1_valid_q, s1_valid_d;
    logic [IW:0]      s1_diff_q,  s1_diff_d;
    logic [IW-1:0]    s1_prev_q,  s1_prev_d;
    logic             o_valid_q,  o_valid_d;
    logic [OW-1:0]    o_data_q,   o_data_d;
    logic             o_sat_q,    o_sat_d;

    logic [EW-1:0]    e_s;
    logic [EW-IW:0]   e_top_s;
    logic             ovf_s;
    logic [IW-1:0]    res_s;

    // Next-state logic: sample capture, stage 1 difference, stage 2 reconstruction.
    always_comb begin
        yprev_d    = yprev_q;
        primed_d   = primed_q;
        s1_valid_d = 1'b0;
        s1_diff_d  = s1_diff_q;
        s1_prev_d  = s1_prev_q;
        o_valid_d  = 1'b0;
        o_data_d   = o_data_q;
        o_sat_d    = o_sat_q;
        e_s        = '0;
        e_top_s    = '0;
        ovf_s      = 1'b0;
        res_s      = '0;

        // Stage 1 always advances; only an accepted, primed sample makes it valid.
        s1_diff_d  = {i_data[IW-1], i_data} - {yprev_q[IW-1], yprev_q};
        s1_prev_d  = yprev_q;
        s1_valid_d = i_ce & primed_q;
        if (i_ce) begin
            yprev_d  = i_data;
            primed_d = 1'b1;
        end else begin
            yprev_d  = yprev_q;
            primed_d = primed_q;
        end

        // Stage 2: sign-extend both operands to EW so the sum cannot overflow.
        e_s = {{(EW-IW){s1_prev_q[IW-1]}}, s1_prev_q}
            + ({{(EW-IW-1){s1_diff_q[IW]}}, s1_diff_q} << LGALPHA);

        // e fits in IW signed bits iff all bits from the IW-1 sign position up agree.
        e_top_s = e_s[EW-1:IW-1];
        ovf_s   = ~((&e_top_s) | ~(|e_top_s));

`ifdef IIRINV_SATURATE_EN
        if (ovf_s) begin
            res_s = e_s[EW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        end else begin
            res_s = e_s[IW-1:0];
        end
`else
        res_s = e_s[IW-1:0];
`endif

        o_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            // Truncate (no rounding) the low IW-OW bits.
            o_data_d = OW'(res_s >> (IW - OW));
            o_sat_d  = o_sat_q | ovf_s;
        end else begin
            o_data_d = o_data_q;
            o_sat_d  = o_sat_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            yprev_q    <= '0;
            primed_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_prev_q  <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= 1'b0;
        end else begin
            yprev_q    <= yprev_d;
            primed_q   <= primed_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_prev_q  <= s1_prev_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_sat_q    <= o_sat_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_iirinv.sv
// -----------------------------------------------------------------------------
// tb_iirinv -- directed self-checking bench for iirinv (IW=16, OW=15, LGALPHA=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_iirinv;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [15:0] din;
    logic        valid;
    logic [14:0] dout;
    logic        sat;

    int checks;
    int failures;

    iirinv #(.IW(16), .OW(15), .LGALPHA(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_ce      (ce),
        .i_data    (din),
        .o_valid   (valid),
        .o_data    (dout),
        .o_sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        din   = 16'h0000;
        tick();
        rst_n = 1'b1;
    endtask

    // Present one sample for exactly one rising edge.
    task automatic strobe(input logic [15:0] v);
        ce  = 1'b1;
        din = v;
        tick();
        ce  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ce    = 1'b0;
        din   = 16'h0000;
        tick();
        do_reset();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (dout !== 15'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
    endtask

    task automatic test_const();
        do_reset();
        strobe(16'h1000);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL const_first_novalid got=%b exp=0", valid); end
        strobe(16'h1000);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL const_latency_early got=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL const_valid got=%b exp=1", valid); end
        checks++; if (dout !== 15'h0800) begin failures++; $display("FAIL const_data got=%h exp=0800", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL const_sat got=%b exp=0", sat); end
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL const_one_pulse got=%b exp=0", valid); end
        checks++; if (dout !== 15'h0800) begin failures++; $display("FAIL const_hold got=%h exp=0800", dout); end
    endtask

    task automatic test_step();
        do_reset();
        strobe(16'h0000);
        tick();
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL step_prime_novalid got=%b exp=0", valid); end
        strobe(16'h0100);
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL step_valid got=%b exp=1", valid); end
        checks++; if (dout !== 15'h0800) begin failures++; $display("FAIL step_data got=%h exp=0800", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL step_sat got=%b exp=0", sat); end
    endtask

    task automatic test_range();
        logic [14:0] exp_pos;
        logic [14:0] exp_neg;
`ifdef IIRINV_SATURATE_EN
        exp_pos = 15'h3FFF;
        exp_neg = 15'h4000;
`else
        exp_pos = 15'h7FF8;
        exp_neg = 15'h0000;
`endif
        do_reset();
        strobe(16'h0000);
        strobe(16'h7FFF);
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pos_valid got=%b exp=1", valid); end
        checks++; if (dout !== exp_pos) begin failures++; $display("FAIL pos_data got=%h exp=%h", dout, exp_pos); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL pos_sat got=%b exp=1", sat); end
        // In-range follow-up sample: e = 0x7FFF, flag must stay set.
        strobe(16'h7FFF);
        tick();
        checks++; if (dout !== 15'h3FFF) begin failures++; $display("FAIL inrange_data got=%h exp=3fff", dout); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b exp=1", sat); end
        do_reset();
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_cleared got=%b exp=0", sat); end
        strobe(16'h0000);
        strobe(16'h8000);
        tick();
        checks++; if (dout !== exp_neg) begin failures++; $display("FAIL neg_data got=%h exp=%h", dout, exp_neg); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL neg_sat got=%b exp=1", sat); end
    endtask

    task automatic test_back_to_back();
        int          npulse;
        int          first_idx;
        int          last_idx;
        logic [14:0] exp_d;
        do_reset();
        npulse    = 0;
        first_idx = -1;
        last_idx  = -1;
        // Samples k*16: each recovered e = (k-1)*16 + 256, o_data = e >> 1.
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                ce  = 1'b1;
                din = 16'(i * 16);
            end else begin
                ce  = 1'b0;
            end
            tick();
            if (valid === 1'b1) begin
                exp_d = 15'((i - 2) * 8 + 128);
                checks++; if (dout !== exp_d) begin failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, dout, exp_d); end
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                npulse++;
            end
        end
        checks++; if (npulse !== 7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", npulse); end
        checks++; if (first_idx !== 2 || last_idx !== 8) begin failures++; $display("FAIL b2b_span got=%0d..%0d exp=2..8", first_idx, last_idx); end

        // Reset on the clock after the 4th strobe discards in-flight samples.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ce  = 1'b1;
            din = 16'(16'h0100 * (i + 1));
            tick();
        end
        ce    = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (valid !== 1'b0 || dout !== 15'h0000 || sat !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b/%h/%b exp=0/0000/0", valid, dout, sat); end
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid === 1'b1) npulse++;
        end
        checks++; if (npulse !== 0) begin failures++; $display("FAIL midreset_novalid got=%0d exp=0", npulse); end
        strobe(16'h1000);
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midreset_primed got=%b exp=0", valid); end
        strobe(16'h1000);
        tick();
        checks++; if (valid !== 1'b1 || dout !== 15'h0800) begin failures++; $display("FAIL midreset_resume got=%b/%h exp=1/0800", valid, dout); end
    endtask

    task automatic test_ce_in_reset();
        int npulse;
        npulse = 0;
        rst_n  = 1'b0;
        ce     = 1'b1;
        din    = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid === 1'b1) npulse++;
        end
        checks++; if (npulse !== 0) begin failures++; $display("FAIL cereset_novalid got=%0d exp=0", npulse); end
        rst_n = 1'b1;
        ce    = 1'b0;
        tick();
        strobe(16'h2000);
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL cereset_prime_only got=%b exp=0", valid); end
        strobe(16'h2000);
        tick();
        checks++; if (valid !== 1'b1 || dout !== 15'h1000) begin failures++; $display("FAIL cereset_second got=%b/%h exp=1/1000", valid, dout); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ce       = 1'b0;
        din      = 16'h0000;
        test_reset();
        test_const();
        test_step();
        test_range();
        test_back_to_back();
        test_ce_in_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
